ssi_encoder_emulator: RTL and testbench

SSI slave (absolute-encoder emulator) that answers an SSI master's clock burst on `ssi_c` by shifting out a latched position word on `ssi_d`, MSB first. It sits in the 4MB test and bring-up path, looped back onto a motor channel's `ssi_c`/`ssi_d` pins. This lets the absolute-encoder read path, including `abs_enc_position_reg`, be exercised without a physical XMARS encoder. The emulated position is loaded from the register interface.

---
 rtl/ssi_encoder_emulator.sv | 151 +++++++++++++++
 tb/tb_ssi_encoder_emulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssi_encoder_emulator.sv
// SSI slave that emulates an absolute encoder: answers a clock burst on ssi_c by shifting out a latched position word.
// Optional feature: define SSI_EMU_GRAY_EN to Gray-code the latched snapshot.
module ssi_encoder_emulator #(
  parameter int DATA_BITS       = 28,
  parameter int MONOFLOP_CYCLES = 2000
) (
  input  logic                 clk_100m,
  input  logic                 rst_syn,
  input  logic                 ssi_c,
  output logic                 ssi_d,
  input  logic [DATA_BITS-1:0] pos_value,
  input  logic                 pos_update,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           abort_cnt
);

  localparam int MONO_W = $clog2(MONOFLOP_CYCLES + 1);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MONO
  } state_t;

  logic [1:0]           sync_q;
  logic                 hist_q;
  logic                 fall;
  logic                 rise;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] pos_hold_q;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] snapshot;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [MONO_W-1:0]    mono_cnt_q, mono_cnt_d;
  logic                 ssi_d_q, ssi_d_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]           abort_cnt_q, abort_cnt_d;
  logic                 mono_done;

  assign fall      = hist_q & ~sync_q[1];
  assign rise      = ~hist_q & sync_q[1];
  assign mono_done = (mono_cnt_q == MONO_W'(MONOFLOP_CYCLES));

`ifdef SSI_EMU_GRAY_EN
  assign snapshot = pos_hold_q ^ (pos_hold_q >> 1);
`else
  assign snapshot = pos_hold_q;
`endif

  // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    mono_cnt_d  = mono_cnt_q;
    ssi_d_d     = ssi_d_q;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;

    case (state_q)
      ST_IDLE: begin
        ssi_d_d    = 1'b1;
        mono_cnt_d = '0;
        if (fall) begin
          shreg_d   = snapshot;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (rise) begin
          mono_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(DATA_BITS)) begin
            // Extra rise after the last data bit: drive the monoflop level.
            ssi_d_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_MONO;
          end else begin
            ssi_d_d   = shreg_q[DATA_BITS-1];
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if (fall) begin
          mono_cnt_d = '0;
        end else if (mono_done) begin
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
          ssi_d_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mono_cnt_d = mono_cnt_q + MONO_W'(1);
        end
      end

      ST_MONO: begin
        ssi_d_d = 1'b0;
        // Edges only retrigger the monoflop; a burst here is never answered.
        if (fall || rise) begin
          mono_cnt_d = '0;
        end else if (mono_done) begin
          ssi_d_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          mono_cnt_d = mono_cnt_q + MONO_W'(1);
        end
      end

      default: begin
        ssi_d_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_100m) begin
    if (rst_syn) begin
      // NOTE: synchronizer and history preset to the idle level so reset release never fakes a fall.
      sync_q      <= 2'b11;
      hist_q      <= 1'b1;
      state_q     <= ST_IDLE;
      pos_hold_q  <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      mono_cnt_q  <= '0;
      ssi_d_q     <= 1'b1;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      sync_q      <= {sync_q[0], ssi_c};
      hist_q      <= sync_q[1];
      state_q     <= state_d;
      if (pos_update) pos_hold_q <= pos_value;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      mono_cnt_q  <= mono_cnt_d;
      ssi_d_q     <= ssi_d_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign ssi_d     = ssi_d_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_ssi_encoder_emulator.sv
// Self-checking bench for ssi_encoder_emulator: an SSI master model drives bursts and compares captured words and counters.
// Honours SSI_EMU_GRAY_EN the same way as the design when computing expected words.
module tb_ssi_encoder_emulator;

  localparam int DW   = 28;
  localparam int MONO = 64;

  logic          clk_100m = 1'b0;
  logic          rst_syn;
  logic          ssi_c;
  logic          ssi_d;
  logic [DW-1:0] pos_value;
  logic          pos_update;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic [7:0]    abort_cnt;

  ssi_encoder_emulator #(
    .DATA_BITS       (DW),
    .MONOFLOP_CYCLES (MONO)
  ) dut (
    .clk_100m   (clk_100m),
    .rst_syn    (rst_syn),
    .ssi_c      (ssi_c),
    .ssi_d      (ssi_d),
    .pos_value  (pos_value),
    .pos_update (pos_update),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .abort_cnt  (abort_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct {
    logic [DW-1:0] pos;
    logic [DW-1:0] exp_word;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] m_hold;
  int            m_frames;
  int            m_aborts;
  logic          saw_high;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Word the master should capture for a given held position.
  function automatic logic [DW-1:0] encode(input logic [DW-1:0] p);
`ifdef SSI_EMU_GRAY_EN
    return p ^ (p >> 1);
`else
    return p;
`endif
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk_100m);
      if (ssi_d === 1'b1) saw_high = 1'b1;
    end
  endtask

  task automatic strobe_pos(input logic [DW-1:0] v);
    pos_value  = v;
    pos_update = 1'b1;
    wait_cyc(1);
    pos_update = 1'b0;
    m_hold     = v;
  endtask

  // Master: n_per clock periods; samples data just before each fall from the second on.
  // Optionally strobes pos_update upd_delay cycles into the fall of period upd_at.
  task automatic burst(input int n_per, input int half, input int upd_at, input int upd_delay,
                       input logic [DW-1:0] upd_val, output logic [DW-1:0] word);
    word = '0;
    for (int i = 1; i <= n_per; i++) begin
      if (i >= 2 && i <= DW + 1) word = {word[DW-2:0], ssi_d};
      ssi_c = 1'b0;
      if (i == upd_at) begin
        wait_cyc(upd_delay);
        pos_value  = upd_val;
        pos_update = 1'b1;
        wait_cyc(1);
        pos_update = 1'b0;
        m_hold     = upd_val;
        wait_cyc(half - upd_delay - 1);
      end else begin
        wait_cyc(half);
      end
      ssi_c = 1'b1;
      if (i < n_per) wait_cyc(half);
    end
  endtask

  // Cycles from the last pin edge until busy drops; also reports ssi_d three cycles in.
  task automatic wait_release(output int n, output logic d_at3);
    n     = -1;
    d_at3 = 1'bx;
    for (int k = 1; k <= MONO + 100; k++) begin
      @(negedge clk_100m);
      if (k == 3) d_at3 = ssi_d;
      if (busy === 1'b0) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[8];
    logic [DW-1:0] word;
    logic [DW-1:0] exp;
    int            n;
    logic          d3;
    int            half;
    int            upd_at;

    ssi_c = 1'b1; rst_syn = 1'b1; pos_update = 1'b0; pos_value = '0;
    m_hold = '0; m_frames = 0; m_aborts = 0; saw_high = 1'b0;
    repeat (3) @(negedge clk_100m);
    rst_syn = 1'b0;
    wait_cyc(2);
    check("rst_ssi_d", 32'(ssi_d), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_abort_cnt", 32'(abort_cnt), 32'd0);

    vecs[0].pos = 28'h0ABCDEF;
    vecs[1].pos = 28'h0000000;
    vecs[2].pos = 28'hFFFFFFF;
    vecs[3].pos = 28'h8000001;
    vecs[4].pos = 28'h5555555;
    for (int i = 5; i < 8; i++) vecs[i].pos = DW'($urandom);
    for (int i = 0; i < 8; i++) vecs[i].exp_word = encode(vecs[i].pos);

    for (int i = 0; i < 8; i++) begin
      strobe_pos(vecs[i].pos);
      wait_cyc(5);
      burst(DW + 1, 10, 0, 0, '0, word);
      check($sformatf("tbl_word[%0d]", i), 32'(word), 32'(vecs[i].exp_word));
      wait_release(n, d3);
      m_frames++;
      check($sformatf("tbl_end_level[%0d]", i), 32'(d3), 32'd0);
      check($sformatf("tbl_mono_len[%0d]", i), 32'(n), 32'(MONO + 4));
      check($sformatf("tbl_idle_d[%0d]", i), 32'(ssi_d), 32'd1);
      check($sformatf("tbl_frames[%0d]", i), 32'(frame_cnt), 32'(m_frames));
      check($sformatf("tbl_aborts[%0d]", i), 32'(abort_cnt), 32'd0);
    end

    // New burst while still in the monoflop: fully ignored.
    strobe_pos(28'h0123456);
    wait_cyc(5);
    burst(DW + 1, 10, 0, 0, '0, word);
    m_frames++;
    check("mono_first_word", 32'(word), 32'(encode(28'h0123456)));
    wait_cyc(MONO / 2);
    check("mono_busy", 32'(busy), 32'd1);
    saw_high = 1'b0;
    burst(5, 10, 0, 0, '0, word);
    wait_release(n, d3);
    check("mono_d_stayed_low", 32'(saw_high), 32'd0);
    check("mono_len_after_ignored", 32'(n), 32'(MONO + 4));
    check("mono_frames", 32'(frame_cnt), 32'(m_frames));

    // pos_update in the very cycle of the latching fall.
    strobe_pos(28'h0000001);
    wait_cyc(5);
    exp = encode(m_hold);
    burst(DW + 1, 10, 1, 2, 28'h1234567, word);
    check("collide_old", 32'(word), 32'(exp));
    wait_release(n, d3);
    m_frames++;
    wait_cyc(5);
    burst(DW + 1, 10, 0, 0, '0, word);
    check("collide_new", 32'(word), 32'(encode(28'h1234567)));
    wait_release(n, d3);
    m_frames++;
    check("collide_frames", 32'(frame_cnt), 32'(m_frames));

    // Random positions, speeds and mid-frame updates.
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) strobe_pos(DW'($urandom));
      wait_cyc(5);
      half   = $urandom_range(4, 12);
      upd_at = $urandom_range(2, DW + 1);
      exp    = encode(m_hold);
      burst(DW + 1, half, upd_at, 1, DW'($urandom), word);
      check($sformatf("rnd_word[%0d]", r), 32'(word), 32'(exp));
      wait_release(n, d3);
      m_frames++;
      check($sformatf("rnd_mono_len[%0d]", r), 32'(n), 32'(MONO + 4));
      check($sformatf("rnd_frames[%0d]", r), 32'(frame_cnt), 32'(m_frames));
    end

    // Clock stops after 10 bits: timeout abort.
    strobe_pos(28'h0FFFFFF);
    wait_cyc(5);
    burst(10, 10, 0, 0, '0, word);
    check("abort_busy_mid", 32'(busy), 32'd1);
    wait_release(n, d3);
    m_aborts++;
    check("abort_len", 32'(n), 32'(MONO + 4));
    check("abort_d", 32'(ssi_d), 32'd1);
    check("abort_cnt_1", 32'(abort_cnt), 32'(m_aborts));
    check("abort_frames", 32'(frame_cnt), 32'(m_frames));

    for (int i = 0; i < 299; i++) begin
      ssi_c = 1'b0;
      wait_cyc(5);
      ssi_c = 1'b1;
      wait_cyc(MONO + 10);
      if (m_aborts < 255) m_aborts++;
      if (m_aborts == 254 && i < 260) check("abort_cnt_254", 32'(abort_cnt), 32'd254);
    end
    check("abort_cnt_sat", 32'(abort_cnt), 32'(m_aborts));
    check("abort_sat_frames", 32'(frame_cnt), 32'(m_frames));

    // Reset in the middle of a frame.
    strobe_pos(28'h0DEAD12);
    wait_cyc(5);
    burst(15, 10, 0, 0, '0, word);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst_syn = 1'b1;
    wait_cyc(1);
    check("rstmid_d", 32'(ssi_d), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_frames", 32'(frame_cnt), 32'd0);
    check("rstmid_aborts", 32'(abort_cnt), 32'd0);
    rst_syn = 1'b0;
    m_hold = '0; m_frames = 0; m_aborts = 0;
    wait_cyc(5);
    burst(DW + 1, 10, 0, 0, '0, word);
    check("rstmid_next_word", 32'(word), 32'(encode(m_hold)));
    wait_release(n, d3);
    m_frames++;
    check("rstmid_next_frames", 32'(frame_cnt), 32'(m_frames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
